// File: rtl/vga_capture_pkg.sv
`default_nettype none
//==============================================================================
// Module   : vga_capture_pkg
// Desc     : Shared VGA constants for the capture and driver ends. It holds the
//            default active raster size, the RGB565 pixel width, the capture
//            FSM state encoding and a counter-width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
//==============================================================================
package vga_capture_pkg;

    // Default active raster, shared with vga_driver so both ends agree.
    localparam int C_VGA_H_ACT = 640;
    localparam int C_VGA_V_ACT = 480;

    // RGB565 pixel width.
    localparam int C_RGB_W = 16;

    // Capture FSM state encoding.
    localparam int         C_ST_W       = 2;
    localparam logic [1:0] C_ST_IDLE    = 2'd0;
    localparam logic [1:0] C_ST_ARMED   = 2'd1;
    localparam logic [1:0] C_ST_CAPTURE = 2'd2;
    localparam logic [1:0] C_ST_DONE    = 2'd3;

    // Width of a counter that must be able to hold the value n itself
    // (a counter may saturate at, or reach, its limit).
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_edge.sv
`default_nettype none
//==============================================================================
// Module   : vga_sync_edge
// Desc     : Input stage for the capture block. It registers hsync, vsync, blank
//            and pixel data once. It also produces single-cycle falling-edge
//            pulses of the registered vsync (frame start) and of the registered
//            blank_n (line end).
// Ports    : clk, rst          - pixel clock, sync active-high reset
//            i_vga_hys/vys     - raw syncs (active-low)
//            i_vga_rgb         - raw RGB565 pixel
//            i_vga_blank_n     - raw active-video flag
//            o_hys_q/o_vys_q   - registered syncs
//            o_rgb_q/o_blank_q - registered pixel / active flag
//            o_vys_fall        - one-cycle pulse on vsync falling edge
//            o_blank_fall      - one-cycle pulse on blank_n falling edge
// Revision : 1.0 - initial release
//==============================================================================
module vga_sync_edge
    import vga_capture_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_vga_hys,
    input  logic               i_vga_vys,
    input  logic [C_RGB_W-1:0] i_vga_rgb,
    input  logic               i_vga_blank_n,
    output logic               o_hys_q,
    output logic               o_vys_q,
    output logic [C_RGB_W-1:0] o_rgb_q,
    output logic               o_blank_q,
    output logic               o_vys_fall,
    output logic               o_blank_fall
);

    logic               r_hys;
    logic               r_vys;
    logic [C_RGB_W-1:0] r_rgb;
    logic               r_blank;
    logic               r_vys_d;
    logic               r_blank_d;

    // Syncs idle high. The delayed copies reset to the idle level as well, so
    // no edge pulse appears when reset is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hys     <= 1'b1;
            r_vys     <= 1'b1;
            r_rgb     <= '0;
            r_blank   <= 1'b0;
            r_vys_d   <= 1'b1;
            r_blank_d <= 1'b0;
        end else begin
            r_hys     <= i_vga_hys;
            r_vys     <= i_vga_vys;
            r_rgb     <= i_vga_rgb;
            r_blank   <= i_vga_blank_n;
            r_vys_d   <= r_vys;
            r_blank_d <= r_blank;
        end
    end

    assign o_hys_q      = r_hys;
    assign o_vys_q      = r_vys;
    assign o_rgb_q      = r_rgb;
    assign o_blank_q    = r_blank;
    assign o_vys_fall   = r_vys_d & ~r_vys;
    assign o_blank_fall = r_blank_d & ~r_blank;

endmodule
`default_nettype wire

// File: rtl/vga_capture.sv
`default_nettype none
//==============================================================================
// Module   : vga_capture
// Desc     : Captures one VGA frame into a linear frame buffer when armed.
//            Active pixels are written to address y*H_ACT+x. The address comes
//            from a running line base plus x, with no multiplier. Short lines,
//            long lines and short frames are flagged on a sticky line_err.
// Ports    : clk, rst     - pixel clock, sync active-high reset
//            cap_en       - arm request (level)
//            vga_hys/vys  - syncs (active-low)
//            vga_rgb      - RGB565 pixel
//            vga_blank_n  - high during active video
//            wr_en        - frame-buffer write strobe
//            wr_addr      - frame-buffer write address
//            wr_data      - frame-buffer write data
//            wr_end       - one-cycle pulse after the last write of a frame
//            busy         - high while capturing
//            line_err     - sticky raster error flag
// Revision : 1.0 - initial release
//==============================================================================
module vga_capture
    import vga_capture_pkg::*;
#(
    parameter int H_ACT  = C_VGA_H_ACT,
    parameter int V_ACT  = C_VGA_V_ACT,
    parameter int ADDR_W = 19
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cap_en,
    input  logic               vga_hys,
    input  logic               vga_vys,
    input  logic [C_RGB_W-1:0] vga_rgb,
    input  logic               vga_blank_n,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [C_RGB_W-1:0] wr_data,
    output logic               wr_end,
    output logic               busy,
    output logic               line_err
);

    // x saturates at H_ACT so overlong lines cannot wrap back into range.
    // y must be able to hold V_ACT, which is the frame-complete condition.
    localparam int XW = cnt_width(H_ACT);
    localparam int YW = cnt_width(V_ACT);

    localparam logic [XW-1:0]     C_H_MAX  = XW'(H_ACT);
    localparam logic [YW-1:0]     C_V_MAX  = YW'(V_ACT);
    localparam logic [ADDR_W-1:0] C_H_STEP = ADDR_W'(H_ACT);

    //--------------------------------------------------------------------------
    // Input stage
    //--------------------------------------------------------------------------
    logic               w_hys_q;
    logic               w_vys_q;
    logic [C_RGB_W-1:0] w_rgb_q;
    logic               w_blank_q;
    logic               w_frame_start;
    logic               w_line_end;

    vga_sync_edge u_sync_edge (
        .clk           (clk),
        .rst           (rst),
        .i_vga_hys     (vga_hys),
        .i_vga_vys     (vga_vys),
        .i_vga_rgb     (vga_rgb),
        .i_vga_blank_n (vga_blank_n),
        .o_hys_q       (w_hys_q),
        .o_vys_q       (w_vys_q),
        .o_rgb_q       (w_rgb_q),
        .o_blank_q     (w_blank_q),
        .o_vys_fall    (w_frame_start),
        .o_blank_fall  (w_line_end)
    );

    // Capture is timed by vsync and blank_n alone. The registered hsync and the
    // registered vsync level are kept only so all video inputs share one
    // pipeline stage.
    logic w_unused_sync;
    assign w_unused_sync = w_hys_q ^ w_vys_q;

    //--------------------------------------------------------------------------
    // State
    //--------------------------------------------------------------------------
    logic [C_ST_W-1:0]  r_state;
    logic [C_ST_W-1:0]  w_state_nxt;
    logic [XW-1:0]      r_x;
    logic [YW-1:0]      r_y;
    logic [ADDR_W-1:0]  r_base;
    logic               r_wr_en;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [C_RGB_W-1:0] r_wr_data;
    logic               r_line_err;

    logic w_y_full;
    logic w_x_in_line;
    logic w_start_cap;
    logic w_in_cap;

    assign w_y_full    = (r_y == C_V_MAX);
    assign w_x_in_line = (r_x < C_H_MAX);
    assign w_in_cap    = (r_state == C_ST_CAPTURE);
    assign w_start_cap = (r_state == C_ST_ARMED) && w_frame_start;

    //--------------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // FSM: next state
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_ST_IDLE: begin
                if (cap_en) begin
                    w_state_nxt = C_ST_ARMED;
                end
            end
            C_ST_ARMED: begin
                if (w_frame_start) begin
                    w_state_nxt = C_ST_CAPTURE;
                end
            end
            C_ST_CAPTURE: begin
                // A frame start that ends the capture is consumed here. The
                // next frame has to be armed again before it is captured.
                if (w_y_full || w_frame_start) begin
                    w_state_nxt = C_ST_DONE;
                end
            end
            C_ST_DONE: begin
                // Holding cap_en high gives back-to-back frame capture.
                w_state_nxt = cap_en ? C_ST_ARMED : C_ST_IDLE;
            end
            default: begin
                w_state_nxt = C_ST_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // FSM: outputs
    //--------------------------------------------------------------------------
    always_comb begin
        busy   = 1'b0;
        wr_end = 1'b0;
        case (r_state)
            C_ST_CAPTURE: busy   = 1'b1;
            C_ST_DONE:    wr_end = 1'b1;
            default: begin
                busy   = 1'b0;
                wr_end = 1'b0;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Raster counters and write port
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x        <= '0;
            r_y        <= '0;
            r_base     <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_line_err <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;

            if (w_start_cap) begin
                // A new armed frame clears the raster position and the sticky
                // error flag.
                r_x        <= '0;
                r_y        <= '0;
                r_base     <= '0;
                r_line_err <= 1'b0;
            end else if (w_in_cap) begin
                if (w_frame_start) begin
                    // The frame was cut short.
                    if (!w_y_full) begin
                        r_line_err <= 1'b1;
                    end
                end else if (w_blank_q) begin
                    if (w_x_in_line) begin
                        if (!w_y_full) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= r_base + ADDR_W'(r_x);
                            r_wr_data <= w_rgb_q;
                        end
                        r_x <= r_x + 1'b1;
                    end else begin
                        // Overlong line: drop the pixel and keep x saturated.
                        r_line_err <= 1'b1;
                    end
                end else if (w_line_end) begin
                    r_x <= '0;
                    // A line end with no counted pixels is ignored. Otherwise
                    // the next line starts at the next full-width line base,
                    // whatever this line's length was.
                    if (r_x != '0) begin
                        r_y    <= r_y + 1'b1;
                        r_base <= r_base + C_H_STEP;
                        if (w_x_in_line) begin
                            r_line_err <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign line_err = r_line_err;

endmodule
`default_nettype wire

// File: tb/tb_vga_capture.sv
`default_nettype none
//==============================================================================
// Module   : tb_vga_capture
// Desc     : Self-checking bench for vga_capture on a reduced raster. It drives
//            small frames and pushes every pixel that should be written onto a
//            scoreboard queue. Writes from the DUT are popped and compared.
// Ports    : none
// Revision : 1.0 - initial release
//==============================================================================
module tb_vga_capture;

    localparam int H  = 16;
    localparam int V  = 8;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          cap_en;
    logic          vga_hys;
    logic          vga_vys;
    logic [15:0]   vga_rgb;
    logic          vga_blank_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          wr_end;
    logic          busy;
    logic          line_err;

    vga_capture #(
        .H_ACT  (H),
        .V_ACT  (V),
        .ADDR_W (AW)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .cap_en      (cap_en),
        .vga_hys     (vga_hys),
        .vga_vys     (vga_vys),
        .vga_rgb     (vga_rgb),
        .vga_blank_n (vga_blank_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_end      (wr_end),
        .busy        (busy),
        .line_err    (line_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard entries hold the expected address and data of each write.
    logic [AW+15:0] exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    int n_wr = 0;
    int n_end = 0;
    int last_addr = 0;
    int last_wr_cyc = 0;
    int end_cyc = 0;
    bit busy_seen = 1'b0;

    int line_len[V];
    bit m_cap = 1'b0;
    int my = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor, sampling away from the active edge.
    always @(negedge clk) begin
        logic [AW+15:0] e;
        if (wr_en === 1'b1) begin
            n_wr++;
            last_addr   = int'(wr_addr);
            last_wr_cyc = cyc;
            check_val("wr_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_val("wr_addr", wr_addr, e[AW+15:16]);
                check_val("wr_data", wr_data, e[15:0]);
            end
        end
        if (wr_end === 1'b1) begin
            n_end++;
            end_cyc = cyc;
        end
        if (busy === 1'b1) busy_seen = 1'b1;
    end

    task automatic px(input logic blank, input logic hs, input logic vs, input logic [15:0] rgb);
        @(negedge clk);
        vga_blank_n = blank;
        vga_hys     = hs;
        vga_vys     = vs;
        vga_rgb     = rgb;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) px(1'b0, 1'b1, 1'b1, 16'h0);
    endtask

    // One line: npix active pixels, then front porch, hsync and back porch.
    task automatic drive_line(input int npix, input logic vs);
        logic [15:0]   d;
        logic [AW-1:0] a;
        for (int mx = 0; mx < npix; mx++) begin
            d = 16'($urandom);
            if (m_cap && mx < H && my < V) begin
                a = AW'(my * H + mx);
                exp_q.push_back({a, d});
            end
            px(1'b1, 1'b1, vs, d);
        end
        for (int i = 0; i < 2; i++) px(1'b0, 1'b1, vs, 16'h0);
        for (int i = 0; i < 3; i++) px(1'b0, 1'b0, vs, 16'h0);
        for (int i = 0; i < 3; i++) px(1'b0, 1'b1, vs, 16'h0);
        if (m_cap && npix > 0) my++;
    endtask

    // Frame: vsync (2 lines), back porch, nlines active lines, optional front porch.
    task automatic drive_frame(input bit armed, input int nlines, input bit fp);
        cap_en = armed;
        idle(3);
        m_cap = armed;
        my    = 0;
        drive_line(0, 1'b0);
        drive_line(0, 1'b0);
        check_val("busy_cap", busy, armed);
        cap_en = 1'b0;
        drive_line(0, 1'b1);
        for (int i = 0; i < nlines; i++) drive_line(line_len[i], 1'b1);
        if (fp) drive_line(0, 1'b1);
    endtask

    initial begin
        int w0;
        int e0;
        rst         = 1'b1;
        cap_en      = 1'b0;
        vga_hys     = 1'b1;
        vga_vys     = 1'b1;
        vga_blank_n = 1'b0;
        vga_rgb     = 16'h0;
        for (int i = 0; i < V; i++) line_len[i] = H;

        // Reset state
        px(1'b0, 1'b1, 1'b1, 16'h0);
        px(1'b0, 1'b1, 1'b1, 16'h0);
        check_val("rst_wr_en", wr_en, 0);
        check_val("rst_wr_addr", wr_addr, 0);
        check_val("rst_wr_data", wr_data, 0);
        check_val("rst_wr_end", wr_end, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_line_err", line_err, 0);
        rst = 1'b0;
        idle(2);

        // Armed full frame
        w0 = n_wr; e0 = n_end;
        drive_frame(1'b1, V, 1'b1);
        idle(6);
        check_val("norm_writes", n_wr - w0, H * V);
        check_val("norm_q_empty", exp_q.size(), 0);
        check_val("norm_wr_end", n_end - e0, 1);
        check_val("norm_end_gap", end_cyc - last_wr_cyc, 2);
        check_val("norm_last_addr", last_addr, H * V - 1);
        check_val("norm_line_err", line_err, 0);
        check_val("norm_busy_after", busy, 0);

        // Unarmed frame
        w0 = n_wr; e0 = n_end; busy_seen = 1'b0;
        drive_frame(1'b0, V, 1'b1);
        idle(6);
        check_val("unarm_writes", n_wr - w0, 0);
        check_val("unarm_busy", busy_seen, 0);
        check_val("unarm_wr_end", n_end - e0, 0);

        // Long line 5
        w0 = n_wr; e0 = n_end;
        line_len[5] = H + 2;
        drive_frame(1'b1, V, 1'b1);
        idle(6);
        line_len[5] = H;
        check_val("long_writes", n_wr - w0, H * V);
        check_val("long_q_empty", exp_q.size(), 0);
        check_val("long_line_err", line_err, 1);
        check_val("long_wr_end", n_end - e0, 1);

        // Clean frame after an error clears line_err
        w0 = n_wr;
        drive_frame(1'b1, V, 1'b1);
        idle(6);
        check_val("clr_writes", n_wr - w0, H * V);
        check_val("clr_line_err", line_err, 0);

        // Short line 0
        w0 = n_wr;
        line_len[0] = H - 4;
        drive_frame(1'b1, V, 1'b1);
        idle(6);
        line_len[0] = H;
        check_val("short_writes", n_wr - w0, H * V - 4);
        check_val("short_q_empty", exp_q.size(), 0);
        check_val("short_line_err", line_err, 1);

        // Early vsync after 4 lines, next frame unarmed
        w0 = n_wr; e0 = n_end;
        drive_frame(1'b1, 4, 1'b0);
        drive_frame(1'b0, V, 1'b1);
        idle(6);
        check_val("early_writes", n_wr - w0, 4 * H);
        check_val("early_wr_end", n_end - e0, 1);
        check_val("early_line_err", line_err, 1);
        check_val("early_last_addr", last_addr, 4 * H - 1);
        check_val("early_q_empty", exp_q.size(), 0);

        // Mid-frame reset after line 2
        e0 = n_end;
        drive_frame(1'b1, 3, 1'b0);
        rst = 1'b1;
        px(1'b0, 1'b1, 1'b1, 16'h0);
        rst = 1'b0;
        exp_q.delete();
        m_cap = 1'b0;
        check_val("mrst_wr_en", wr_en, 0);
        check_val("mrst_wr_addr", wr_addr, 0);
        check_val("mrst_wr_data", wr_data, 0);
        check_val("mrst_busy", busy, 0);
        check_val("mrst_line_err", line_err, 0);
        w0 = n_wr;
        for (int i = 3; i < V; i++) drive_line(H, 1'b1);
        drive_line(0, 1'b1);
        idle(4);
        check_val("mrst_no_writes", n_wr - w0, 0);
        check_val("mrst_no_wr_end", n_end - e0, 0);

        // Re-arm and capture a full frame from address 0
        w0 = n_wr; e0 = n_end;
        drive_frame(1'b1, V, 1'b1);
        idle(6);
        check_val("rearm_writes", n_wr - w0, H * V);
        check_val("rearm_q_empty", exp_q.size(), 0);
        check_val("rearm_wr_end", n_end - e0, 1);
        check_val("rearm_line_err", line_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 Parameter H_ACT, default 640, active pixels per line.
REQ-002 Parameter V_ACT, default 480, active lines per frame.
REQ-003 Parameter ADDR_W, default 19, frame-buffer write-address width, which SHALL satisfy 2^ADDR_W >= H_ACT*V_ACT.
REQ-004 clk  in  1  pixel clock, the only clock.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 cap_en  in  1  arm request; level-sensitive, sampled at frame boundary.
REQ-007 vga_hys  in  1  horizontal sync, active-low.
REQ-008 vga_vys  in  1  vertical sync, active-low.
REQ-009 vga_rgb  in  16  RGB565 pixel.
REQ-010 vga_blank_n  in  1  high = active video pixel.
REQ-011 wr_en  out  1  frame-buffer write strobe, one pixel per cycle.
REQ-012 wr_addr  out  ADDR_W  linear pixel address y*H_ACT+x.
REQ-013 wr_data  out  16  pixel data.
REQ-014 wr_end  out  1  one-cycle pulse after the last write of a captured frame.
REQ-015 busy  out  1  high while a frame is being captured.
REQ-016 line_err  out  1  sticky flag for a short or long line or a short frame; cleared by reset or a new armed frame.

Function
REQ-017 All four video inputs SHALL be registered once before use; wr_en, wr_addr and wr_data SHALL be registered, giving 2-cycle latency from an input pixel to its write.
REQ-018 Frame start SHALL be the falling edge of registered vga_vys; line end SHALL be the falling edge of registered vga_blank_n.
REQ-019 FSM states: IDLE, ARMED, CAPTURE, DONE.
REQ-020 IDLE->ARMED when cap_en=1; ARMED->CAPTURE on frame start; CAPTURE->DONE when line counter reaches V_ACT or on the next frame start; DONE->IDLE after one cycle; no other transitions.
REQ-021 In DONE, wr_end SHALL pulse for exactly one cycle.
REQ-022 cap_en=1 while in DONE SHALL re-arm, with DONE->ARMED, to allow continuous capture.
REQ-023 In CAPTURE, each cycle with registered vga_blank_n=1, x<H_ACT and y<V_ACT SHALL produce a write; pixels with x>=H_ACT SHALL be dropped and SHALL set line_err.
REQ-024 Counter x SHALL clear at line end; y SHALL increment at line end only if x>0.
REQ-025 A line end with 0<x<H_ACT SHALL set line_err; the address SHALL then realign to y*H_ACT at the next line.
REQ-026 wr_addr SHALL be generated by a line-base register plus x, using adders only, with no multiplier.
REQ-027 A frame start during CAPTURE with y<V_ACT SHALL set line_err and go to DONE; that frame start is not reused, and the next frame requires ARMED.
REQ-028 Deasserting cap_en during CAPTURE SHALL NOT abort the frame.
REQ-029 Sync pulses and blanking SHALL NOT affect output in IDLE or ARMED; wr_en SHALL be 0 outside CAPTURE.
REQ-030 busy SHALL be 1 exactly in CAPTURE.

Reset
REQ-031 rst SHALL put the FSM in IDLE and clear x, y, line base, all input registers (syncs reset to 1), wr_en, wr_addr, wr_data, wr_end, busy and line_err on the next clk edge.
REQ-032 rst mid-frame SHALL abandon the frame with no wr_end; capture SHALL resume only via a new cap_en and a new frame start.

Structure
REQ-033 H_ACT/V_ACT defaults and the RGB565 width SHALL live in the shared VGA constants include used by vga_driver, so both ends match.
REQ-034 One sub-module, vga_sync_edge, SHALL register the syncs and blank and output falling-edge pulses; everything else is inline.

Verification
REQ-035 Reset, then arm: rst for 2 cycles, cap_en=1, drive one 640x480 frame from vga_driver timing -> 307200 writes, addresses 0..307199 contiguous, wr_end one pulse 2 cycles after the last write, line_err=0.
REQ-036 Unarmed frame: cap_en=0 for a whole frame -> zero wr_en, busy=0.
REQ-037 Long line: line 5 has 642 active pixels -> 640 writes for that line, line 6 starts at address 3840, line_err=1.
REQ-038 Short line: line 0 has 600 pixels -> line 1 first write address 640, line_err=1.
REQ-039 Early vsync after 100 lines -> DONE, wr_end pulse, line_err=1, last address 63999.
REQ-040 Mid-frame reset at line 200 -> outputs cleared next cycle, no wr_end; re-arm and capture the next full frame from address 0.
